// File: rtl/inst_queue_if.sv
// Fetch/decode side bus of the instruction queue.
//
// Handshake: fetch offers an instruction by raising fetch_valid; it is taken
// on a rising edge only when fetch_stall is low in that cycle (otherwise fetch
// must re-present it). Decode sees the head entry while dec_valid is high and
// consumes it on a rising edge where dec_valid && dec_ready. flush is a
// one-cycle command that empties the queue on the edge it is sampled.
interface inst_queue_if #(
    parameter int PC_W   = 16,
    parameter int ADDR_W = 2
);
    logic              fetch_valid;
    logic [7:0]        inst_code_high;
    logic [7:0]        inst_code_low;
    logic [PC_W-1:0]   fetch_pc;
    logic              fetch_stall;
    logic              flush;
    logic              dec_valid;
    logic              dec_ready;
    logic [15:0]       dec_inst;
    logic [PC_W-1:0]   dec_pc;
    logic [ADDR_W:0]   count;

    // Environment side: fetch, decode and the redirect source.
    modport master (
        output fetch_valid, inst_code_high, inst_code_low, fetch_pc, flush, dec_ready,
        input  fetch_stall, dec_valid, dec_inst, dec_pc, count
    );

    // Queue side.
    modport slave (
        input  fetch_valid, inst_code_high, inst_code_low, fetch_pc, flush, dec_ready,
        output fetch_stall, dec_valid, dec_inst, dec_pc, count
    );
endinterface

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry FIFO of
// {instruction, pc}. All outputs decode from registers, so no input reaches
// an output combinationally; a full queue refuses a push even if decode pops
// in the same cycle.
module inst_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int PC_W   = 16
) (
    input  logic         clk,
    input  logic         reset,
    inst_queue_if.slave  q_if
);
    localparam int              ENTRY_W = 16 + PC_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]    count_q, count_d;

    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign push  = q_if.fetch_valid && !full;
    assign pop   = !empty && q_if.dec_ready;
    assign head  = mem_q[rd_ptr_q];

    assign q_if.fetch_stall = full;
    assign q_if.dec_valid   = !empty;
    assign q_if.count       = count_q;
    assign q_if.dec_inst    = empty ? 16'h0000 : head[ENTRY_W-1:PC_W];
    assign q_if.dec_pc      = empty ? '0 : head[PC_W-1:0];

    // Next pointers and occupancy; flush overrides any same-cycle push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (q_if.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; a flushed push is simply not written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push && !q_if.flush) begin
            mem_q[wr_ptr_q] <= {q_if.inst_code_high, q_if.inst_code_low, q_if.fetch_pc};
        end
    end
endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: directed scenarios with literal expectations, then
// random traffic, all checked every cycle against a queue-based model.
module tb_inst_queue;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int PC_W   = 16;

    logic clk;
    logic rst_n;

    inst_queue_if #(.PC_W(PC_W), .ADDR_W(ADDR_W)) bus ();

    inst_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PC_W(PC_W)) u_dut (
        .clk   (clk),
        .reset (rst_n),
        .q_if  (bus)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard / model ----------------
    // Each entry is {inst[15:0], pc[15:0]} in arrival order.
    logic [31:0] exp_q[$];
    bit          m_pop;
    bit          m_push;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
        end else if (bus.flush) begin
            exp_q.delete();
        end else begin
            m_pop  = (exp_q.size() != 0) && bus.dec_ready;
            m_push = bus.fetch_valid && (exp_q.size() != DEPTH);
            if (m_pop)  void'(exp_q.pop_front());
            if (m_push) exp_q.push_back({bus.inst_code_high, bus.inst_code_low, bus.fetch_pc});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every falling edge: outputs must match the model.
    always @(negedge clk) begin
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        e_inst = (exp_q.size() != 0) ? {16'h0, exp_q[0][31:16]} : 32'h0;
        e_pc   = (exp_q.size() != 0) ? {16'h0, exp_q[0][15:0]}  : 32'h0;
        chk("cmp_dec_valid",   {31'h0, bus.dec_valid},   {31'h0, exp_q.size() != 0});
        chk("cmp_fetch_stall", {31'h0, bus.fetch_stall}, {31'h0, exp_q.size() == DEPTH});
        chk("cmp_count",       {29'h0, bus.count},       32'(exp_q.size()));
        chk("cmp_dec_inst",    {16'h0, bus.dec_inst},    e_inst);
        chk("cmp_dec_pc",      {16'h0, bus.dec_pc},      e_pc);
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit fv, input logic [7:0] hi, input logic [7:0] lo,
                         input logic [15:0] pc, input bit rdy, input bit fl);
        bus.fetch_valid    = fv;
        bus.inst_code_high = hi;
        bus.inst_code_low  = lo;
        bus.fetch_pc       = pc;
        bus.dec_ready      = rdy;
        bus.flush          = fl;
    endtask

    // Advance one edge; inputs change and literal checks happen 1 ns later.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        idle();
        repeat (3) cycle();
        chk("rst_dec_valid", {31'h0, bus.dec_valid}, 32'h0);
        chk("rst_fetch_stall", {31'h0, bus.fetch_stall}, 32'h0);
        rst_n = 1'b1;
        cycle();
        chk("post_rst_dec_valid", {31'h0, bus.dec_valid}, 32'h0);
        chk("post_rst_dec_inst", {16'h0, bus.dec_inst}, 32'h0);
        chk("post_rst_dec_pc", {16'h0, bus.dec_pc}, 32'h0);
        chk("post_rst_count", {29'h0, bus.count}, 32'h0);

        // Single push then pop.
        drive(1'b1, 8'h12, 8'h34, 16'h000C, 1'b0, 1'b0);
        cycle();
        idle();
        chk("single_valid", {31'h0, bus.dec_valid}, 32'h1);
        chk("single_inst", {16'h0, bus.dec_inst}, 32'h1234);
        chk("single_pc", {16'h0, bus.dec_pc}, 32'h000C);
        chk("single_count", {29'h0, bus.count}, 32'h1);
        drive(1'b0, 8'h00, 8'h00, 16'h0000, 1'b1, 1'b0);
        cycle();
        idle();
        chk("single_pop_valid", {31'h0, bus.dec_valid}, 32'h0);
        chk("single_pop_count", {29'h0, bus.count}, 32'h0);

        // Fill to full, refused 5th push, then drain in order.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'hA0 + 8'(i), 8'h50 + 8'(i), 16'h000C + 16'(i), 1'b0, 1'b0);
            cycle();
        end
        chk("fill_count", {29'h0, bus.count}, 32'h4);
        chk("fill_stall", {31'h0, bus.fetch_stall}, 32'h1);
        drive(1'b1, 8'hEE, 8'hEE, 16'h0010, 1'b0, 1'b0);
        cycle();
        chk("fill_refused_count", {29'h0, bus.count}, 32'h4);
        chk("fill_refused_head", {16'h0, bus.dec_pc}, 32'h000C);
        drive(1'b0, 8'h00, 8'h00, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc", {16'h0, bus.dec_pc}, 32'h000C + 32'(i));
            cycle();
        end
        idle();
        chk("drain_empty", {31'h0, bus.dec_valid}, 32'h0);

        // Full with simultaneous push and pop: pop only.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'hB0, 8'h00 + 8'(i), 16'h000C + 16'(i), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, 8'hCC, 8'hCC, 16'h0010, 1'b1, 1'b0);
        cycle();
        idle();
        chk("full_pp_count", {29'h0, bus.count}, 32'h3);
        chk("full_pp_stall", {31'h0, bus.fetch_stall}, 32'h0);
        chk("full_pp_pc", {16'h0, bus.dec_pc}, 32'h000D);
        drive(1'b0, 8'h00, 8'h00, 16'h0000, 1'b1, 1'b0);
        repeat (3) cycle();
        idle();

        // Streaming through the wrap point.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'h70, 8'(i), 16'h0020 + 16'(i), 1'b1, 1'b0);
            cycle();
            chk("stream_valid", {31'h0, bus.dec_valid}, 32'h1);
            chk("stream_pc", {16'h0, bus.dec_pc}, 32'h0020 + 32'(i));
            chk("stream_count", {29'h0, bus.count}, 32'h1);
        end
        drive(1'b0, 8'h00, 8'h00, 16'h0000, 1'b1, 1'b0);
        cycle();
        idle();
        chk("stream_end_count", {29'h0, bus.count}, 32'h0);

        // Flush beats same-cycle push and pop.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h30, 8'(i), 16'h0030 + 16'(i), 1'b0, 1'b0);
            cycle();
        end
        chk("pre_flush_count", {29'h0, bus.count}, 32'h3);
        drive(1'b1, 8'h33, 8'h33, 16'h0033, 1'b1, 1'b1);
        cycle();
        chk("flush_count", {29'h0, bus.count}, 32'h0);
        chk("flush_valid", {31'h0, bus.dec_valid}, 32'h0);
        chk("flush_stall", {31'h0, bus.fetch_stall}, 32'h0);
        drive(1'b1, 8'h40, 8'h41, 16'h0040, 1'b0, 1'b0);
        cycle();
        idle();
        chk("post_flush_pc", {16'h0, bus.dec_pc}, 32'h0040);
        chk("post_flush_inst", {16'h0, bus.dec_inst}, 32'h4041);

        // Asynchronous reset mid-stream clears outputs before the next edge.
        drive(1'b1, 8'h50, 8'h51, 16'h0050, 1'b0, 1'b0);
        cycle();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'h0, bus.dec_valid}, 32'h0);
        chk("async_rst_count", {29'h0, bus.count}, 32'h0);
        chk("async_rst_pc", {16'h0, bus.dec_pc}, 32'h0);
        cycle();
        rst_n = 1'b1;
        cycle();

        // Random traffic, checked by the per-cycle compare process.
        for (int n = 0; n < 2000; n++) begin
            drive(($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom),
                  16'($urandom), ($urandom_range(0, 9) < 5), ($urandom_range(0, 39) == 0));
            cycle();
        end
        idle();
        repeat (2) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
